tc_program_fetch_arbiter: RTL and testbench

Sequences and shares the single 8-bit address port of the 8-bit program ROM (`TC_Program8_1`-style, combinational read) between two requesters. The first is the CPU instruction fetch, which needs INSTR_BYTES consecutive bytes assembled into one instruction word. The second is a single-byte data read port for constant/table loads. It sits between the ROM and the CPU front end, drives the ROM address, and holds the ROM reset inactive.

---
 rtl/tc_prog_arb_pkg.sv | 17 +
 rtl/tc_program_fetch_arbiter_assembler.sv | 38 +++
 rtl/tc_program_fetch_arbiter.sv | 108 ++++++++++
 tb/tb_tc_program_fetch_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tc_prog_arb_pkg.sv
// Shared types and sizes for the program-ROM fetch arbiter.
// The FSM state type is shared so that the top and any bound checkers decode it the same way.
package tc_prog_arb_pkg;

    localparam int ROM_ADDR_W      = 8;
    localparam int MAX_INSTR_BYTES = 4;
    localparam int INSTR_W         = 8 * MAX_INSTR_BYTES;
    localparam int BYTE_IDX_W      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DATA  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/tc_program_fetch_arbiter_assembler.sv
// Builds one little-endian instruction word from consecutive ROM bytes.
// The byte counter also serves as the ROM address offset while a fetch is in progress.
module tc_instr_assembler
    import tc_prog_arb_pkg::*;
#(
    parameter int INSTR_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    input  logic [7:0]            byte_in,
    output logic [BYTE_IDX_W-1:0] k,
    output logic [INSTR_W-1:0]    instr,
    output logic                  done
);

    assign done = en && (k == BYTE_IDX_W'(INSTR_BYTES - 1));

    // Only lanes below INSTR_BYTES are ever written, so the upper bits stay zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k     <= '0;
            instr <= '0;
        end else if (clear) begin
            k     <= '0;
            instr <= '0;
        end else if (en) begin
            for (int i = 0; i < MAX_INSTR_BYTES; i++) begin
                if (i < INSTR_BYTES && BYTE_IDX_W'(i) == k) begin
                    instr[8*i +: 8] <= byte_in;
                end
            end
            k <= done ? '0 : k + 1'b1;
        end
    end

endmodule

// File: rtl/tc_program_fetch_arbiter.sv
// Shares the program ROM address port between instruction fetch and single-byte data reads.
// Ties alternate between the two requesters; only one grant is issued per cycle, and only in IDLE.
module tc_program_fetch_arbiter
    import tc_prog_arb_pkg::*;
#(
    parameter int    UUID        = 0,
    parameter string NAME        = "",
    parameter int    INSTR_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ROM_ADDR_W-1:0] fetch_pc,
    output logic                  fetch_ready,
    output logic                  instr_valid,
    output logic [INSTR_W-1:0]    instr,
    input  logic                  instr_ready,
    input  logic                  data_req,
    input  logic [ROM_ADDR_W-1:0] data_addr,
    output logic                  data_grant,
    output logic                  data_valid,
    output logic [7:0]            data_out,
    output logic [ROM_ADDR_W-1:0] rom_address,
    output logic                  rom_rst,
    input  logic [7:0]            rom_out
);

    // Handshakes: a fetch is accepted when fetch_req & fetch_ready, a data read when
    // data_req & data_grant, and an instruction is consumed when instr_valid & instr_ready;
    // requesters must hold their request and address until accepted.

    arb_state_t            state, state_nxt;
    logic [ROM_ADDR_W-1:0] pc_q, addr_q;
    logic                  last_data;
    logic                  asm_clear, asm_en, asm_done;
    logic [BYTE_IDX_W-1:0] byte_idx;

    assign rom_rst     = 1'b0;
    assign instr_valid = (state == HOLD);

    tc_instr_assembler #(.INSTR_BYTES(INSTR_BYTES)) u_asm (
        .clk     (clk),
        .rst     (rst),
        .clear   (asm_clear),
        .en      (asm_en),
        .byte_in (rom_out),
        .k       (byte_idx),
        .instr   (instr),
        .done    (asm_done)
    );

    // Grants are masked while reset is held so nothing is accepted before release.
    always_comb begin
        state_nxt   = state;
        fetch_ready = 1'b0;
        data_grant  = 1'b0;
        asm_clear   = 1'b0;
        asm_en      = 1'b0;
        rom_address = '0;
        case (state)
            IDLE: begin
                if (rst && fetch_req && (!data_req || last_data)) begin
                    fetch_ready = 1'b1;
                    asm_clear   = 1'b1;
                    state_nxt   = FETCH;
                end else if (rst && data_req) begin
                    data_grant = 1'b1;
                    state_nxt  = DATA;
                end
            end
            FETCH: begin
                rom_address = pc_q + ROM_ADDR_W'(byte_idx);
                asm_en      = 1'b1;
                if (asm_done) state_nxt = HOLD;
            end
            HOLD: begin
                if (instr_ready) state_nxt = IDLE;
            end
            DATA: begin
                rom_address = addr_q;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc_q       <= '0;
            addr_q     <= '0;
            last_data  <= 1'b1;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            data_valid <= (state == DATA);
            if (fetch_ready) pc_q <= fetch_pc;
            if (data_grant) addr_q <= data_addr;
            if (state == FETCH && asm_done) last_data <= 1'b0;
            if (state == DATA) begin
                last_data <= 1'b1;
                data_out  <= rom_out;
            end
        end
    end

endmodule

// File: tb/tb_tc_program_fetch_arbiter.sv
// Directed bench for the program fetch arbiter: reset, fetch, wrap, contention,
// backpressure and asynchronous reset during a fetch, against a behavioural ROM.
module tb_tc_program_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [7:0]  fetch_pc;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        data_req;
    logic [7:0]  data_addr;
    logic        data_grant;
    logic        data_valid;
    logic [7:0]  data_out;
    logic [7:0]  rom_address;
    logic        rom_rst;
    logic [7:0]  rom_out;

    logic [7:0]  rom [256];
    int          checks   = 0;
    int          failures = 0;

    assign rom_out = rom[rom_address];

    tc_program_fetch_arbiter #(.UUID(0), .NAME("fetch_arb"), .INSTR_BYTES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .data_req    (data_req),
        .data_addr   (data_addr),
        .data_grant  (data_grant),
        .data_valid  (data_valid),
        .data_out    (data_out),
        .rom_address (rom_address),
        .rom_rst     (rom_rst),
        .rom_out     (rom_out)
    );

    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in the cycle the fetch should be accepted; returns in the first HOLD cycle.
    task automatic run_fetch(input logic [31:0] addrs, input logic [31:0] exp_instr);
        #1;
        chk("fetch_ready_accept", fetch_ready, 1);
        chk("no_data_grant_on_fetch", data_grant, 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            chk("fetch_rom_address", rom_address, addrs[8*k +: 8]);
            chk("fetch_ready_busy", fetch_ready, 0);
            chk("data_grant_busy", data_grant, 0);
            chk("instr_valid_busy", instr_valid, 0);
        end
        cyc();
        #1;
        chk("instr_valid_hold", instr_valid, 1);
        chk("instr_value", instr, exp_instr);
        chk("hold_rom_address", rom_address, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
        rom[8'h10] = 8'h11; rom[8'h11] = 8'h22; rom[8'h12] = 8'h33; rom[8'h13] = 8'h44;
        rom[8'hFE] = 8'hA0; rom[8'hFF] = 8'hA1; rom[8'h00] = 8'hA2; rom[8'h01] = 8'hA3;
        rom[8'h20] = 8'hC1; rom[8'h21] = 8'hC2; rom[8'h22] = 8'hC3; rom[8'h23] = 8'hC4;
        rom[8'h40] = 8'h77;
        rom[8'h80] = 8'h99;

        // Reset held with both requests active.
        rst = 1'b0; fetch_req = 1'b1; data_req = 1'b1;
        fetch_pc = 8'h10; data_addr = 8'h40; instr_ready = 1'b0;
        repeat (3) cyc();
        #1;
        chk("rst_fetch_ready", fetch_ready, 0);
        chk("rst_data_grant", data_grant, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_rom_address", rom_address, 0);
        chk("rst_rom_rst", rom_rst, 0);

        // Release: fetch wins the first tie.
        rst = 1'b1;
        run_fetch(32'h13121110, 32'h44332211);

        // Backpressure: consumer stalls, data request stays pending.
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("bp_instr_valid", instr_valid, 1);
            chk("bp_instr_stable", instr, 32'h44332211);
            chk("bp_data_grant", data_grant, 0);
            chk("bp_rom_address", rom_address, 0);
        end
        instr_ready = 1'b1;

        cyc();
        fetch_pc = 8'hFE;
        #1;
        chk("alt_data_grant", data_grant, 1);
        chk("alt_fetch_ready", fetch_ready, 0);
        chk("after_hs_instr_valid", instr_valid, 0);
        cyc();
        #1;
        chk("data_rom_address", rom_address, 8'h40);
        chk("data_valid_early", data_valid, 0);
        cyc();
        #1;
        chk("data_valid_pulse", data_valid, 1);
        chk("data_out_value", data_out, 8'h77);

        // Wrapping fetch issued in the same cycle the data result appears.
        data_addr = 8'h80;
        run_fetch(32'h0100FFFE, 32'hA3A2A1A0);
        chk("data_out_held", data_out, 8'h77);
        chk("data_valid_single", data_valid, 0);

        cyc();
        #1;
        chk("alt2_data_grant", data_grant, 1);
        chk("alt2_fetch_ready", fetch_ready, 0);
        cyc();
        #1;
        chk("data2_rom_address", rom_address, 8'h80);
        cyc();
        #1;
        chk("data2_valid", data_valid, 1);
        chk("data2_out", data_out, 8'h99);
        chk("alt3_fetch_ready", fetch_ready, 1);

        // Fetch interrupted by asynchronous reset after two bytes.
        data_req = 1'b0; fetch_pc = 8'h10;
        cyc();
        #1;
        chk("mid_addr0", rom_address, 8'h10);
        cyc();
        #1;
        chk("mid_addr1", rom_address, 8'h11);
        cyc();
        #1;
        chk("mid_partial_instr", instr, 32'h00002211);
        rst = 1'b0;
        #1;
        chk("async_rst_instr", instr, 0);
        chk("async_rst_instr_valid", instr_valid, 0);
        chk("async_rst_rom_address", rom_address, 0);
        chk("async_rst_fetch_ready", fetch_ready, 0);
        chk("async_rst_data_out", data_out, 0);
        cyc();
        rst = 1'b1; fetch_pc = 8'h20;
        run_fetch(32'h23222120, 32'hC4C3C2C1);
        cyc();
        #1;
        chk("final_instr_valid", instr_valid, 0);
        chk("final_fetch_ready", fetch_ready, 1);
        fetch_req = 1'b0;
        instr_ready = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
